// File: rtl/sram_scan_pkg.sv
// sram_scan_pkg: shared widths, frame layout, FSM encoding and slot-validity
// helper for the GPIO scan SRAM controller.
package sram_scan_pkg;

  localparam int unsigned NUM_SRAM = 11;
  localparam logic [NUM_SRAM-1:0] INVALID_MASK = 11'b000_1000_0000;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WMASK_W  = 4;
  localparam int unsigned READ_LAT = 1;

  localparam int unsigned PORT_W  = ADDR_W + DATA_W + 2 + WMASK_W;
  localparam int unsigned FRAME_W = SEL_W + 2 * PORT_W;

  // LSB offsets of each frame field (bit 0 is the last bit shifted in)
  localparam int unsigned WMASK1_LSB = 0;
  localparam int unsigned WEB1_BIT   = WMASK1_LSB + WMASK_W;
  localparam int unsigned CSB1_BIT   = WEB1_BIT + 1;
  localparam int unsigned DIN1_LSB   = CSB1_BIT + 1;
  localparam int unsigned ADDR1_LSB  = DIN1_LSB + DATA_W;
  localparam int unsigned WMASK0_LSB = ADDR1_LSB + ADDR_W;
  localparam int unsigned WEB0_BIT   = WMASK0_LSB + WMASK_W;
  localparam int unsigned CSB0_BIT   = WEB0_BIT + 1;
  localparam int unsigned DIN0_LSB   = CSB0_BIT + 1;
  localparam int unsigned ADDR0_LSB  = DIN0_LSB + DATA_W;
  localparam int unsigned SEL_LSB    = ADDR0_LSB + ADDR_W;

  // Latency counter holds 0..READ_LAT-1
  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  din;
    logic               csb;
    logic               web;
    logic [WMASK_W-1:0] wmask;
  } port_fields_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    port_fields_t     p0;
    port_fields_t     p1;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  // Slot is usable: in range and populated with a macro
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    logic [(2**SEL_W)-1:0] bad;
    bad = {{((2**SEL_W) - NUM_SRAM){1'b1}}, INVALID_MASK};
    return ~bad[sel];
  endfunction

endpackage

// File: rtl/scan_frame_reg.sv
// scan_frame_reg: FRAME_W-bit command/response shift register.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   scan_en, scan_in  shift enable (priority) and serial input, MSB-first
//   load_en           replace both din fields with load_din0/load_din1
//   frame             parallel view of the register
//   scan_out          serial output, frame MSB
module scan_frame_reg
  import sram_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_en,
  input  logic               scan_in,
  input  logic               load_en,
  input  logic [DATA_W-1:0]  load_din0,
  input  logic [DATA_W-1:0]  load_din1,
  output logic [FRAME_W-1:0] frame,
  output logic               scan_out
);

  logic [FRAME_W-1:0] frame_d, frame_q;

  // Shift wins over load; load touches only the din fields
  always_comb begin
    frame_d = frame_q;
    if (scan_en) begin
      frame_d = {frame_q[FRAME_W-2:0], scan_in};
    end else if (load_en) begin
      frame_d[DIN0_LSB +: DATA_W] = load_din0;
      frame_d[DIN1_LSB +: DATA_W] = load_din1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_q <= '0;
    else        frame_q <= frame_d;
  end

  assign frame    = frame_q;
  assign scan_out = frame_q[FRAME_W-1];

endmodule

// File: rtl/sram_scan_ctrl.sv
// sram_scan_ctrl: scan-protocol responder driving an array of SRAM macros.
// A shifted-in frame selects a slot and per-port addr/din/csb/web/wmask; a
// global_csb low strobe issues one access, reads are captured and can be
// loaded back into the frame's din fields for shifting out.
// Ports:
//   clk, resetn               clock, async active-low reset
//   scan_en, scan_in/out      serial frame access
//   sram_load                 load captured read data into the frame
//   global_csb                active-low access strobe (edge-qualified)
//   sram_csb0/1               per-slot chip selects, active low
//   sram_web/wmask/addr/din*  broadcast port controls
//   sram_dout0/1              flattened per-slot read data
//   busy, sel_err             FSM active, last strobe hit an invalid slot
module sram_scan_ctrl
  import sram_scan_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       scan_en,
  input  logic                       scan_in,
  output logic                       scan_out,
  input  logic                       sram_load,
  input  logic                       global_csb,
  output logic [NUM_SRAM-1:0]        sram_csb0,
  output logic [NUM_SRAM-1:0]        sram_csb1,
  output logic                       sram_web0,
  output logic                       sram_web1,
  output logic [WMASK_W-1:0]         sram_wmask0,
  output logic [WMASK_W-1:0]         sram_wmask1,
  output logic [ADDR_W-1:0]          sram_addr0,
  output logic [ADDR_W-1:0]          sram_addr1,
  output logic [DATA_W-1:0]          sram_din0,
  output logic [DATA_W-1:0]          sram_din1,
  input  logic [NUM_SRAM*DATA_W-1:0] sram_dout0,
  input  logic [NUM_SRAM*DATA_W-1:0] sram_dout1,
  output logic                       busy,
  output logic                       sel_err
);

  state_e               state_d, state_q;
  logic [SEL_W-1:0]     sel_d, sel_q;
  logic                 rd0_d, rd0_q, rd1_d, rd1_q;
  logic [LAT_W-1:0]     cnt_d, cnt_q;
  logic                 armed_d, armed_q;
  logic                 load_pend_d, load_pend_q;
  logic [DATA_W-1:0]    dout0_d, dout0_q, dout1_d, dout1_q;
  logic [NUM_SRAM-1:0]  csb0_d, csb0_q, csb1_d, csb1_q;
  logic                 web0_d, web0_q, web1_d, web1_q;
  logic [WMASK_W-1:0]   wmask0_d, wmask0_q, wmask1_d, wmask1_q;
  logic [ADDR_W-1:0]    addr0_d, addr0_q, addr1_d, addr1_q;
  logic [DATA_W-1:0]    din0_d, din0_q, din1_d, din1_q;
  logic                 busy_d, busy_q, sel_err_d, sel_err_q;

  logic [FRAME_W-1:0]   frame;
  frame_t               fr;
  logic                 load_en, load_req, strobe;
  logic [DATA_W-1:0]    ld0, ld1, dsel0, dsel1;

  assign fr = frame_t'(frame);

  scan_frame_reg u_frame (
    .clk       (clk),
    .rst_n     (resetn),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .load_en   (load_en),
    .load_din0 (ld0),
    .load_din1 (ld1),
    .frame     (frame),
    .scan_out  (scan_out)
  );

  // Read-data mux for the snapshotted slot
  always_comb begin
    dsel0 = '0;
    dsel1 = '0;
    for (int k = 0; k < NUM_SRAM; k++) begin
      if (sel_q == SEL_W'(k)) begin
        dsel0 = sram_dout0[k*DATA_W +: DATA_W];
        dsel1 = sram_dout1[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rd0_d       = rd0_q;
    rd1_d       = rd1_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    load_pend_d = load_pend_q;
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    csb0_d      = csb0_q;
    csb1_d      = csb1_q;
    web0_d      = web0_q;
    web1_d      = web1_q;
    wmask0_d    = wmask0_q;
    wmask1_d    = wmask1_q;
    addr0_d     = addr0_q;
    addr1_d     = addr1_q;
    din0_d      = din0_q;
    din1_d      = din1_q;
    sel_err_d   = sel_err_q;
    load_en     = 1'b0;
    ld0         = dout0_q;
    ld1         = dout1_q;

    load_req = sram_load && !scan_en;
    strobe   = (state_q == ST_IDLE) && !scan_en && !global_csb && armed_q;

    // Seeing global_csb high re-arms the strobe
    if (global_csb) armed_d = 1'b1;
    if (scan_en)    load_pend_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_req) load_en = 1'b1;
        if (strobe) begin
          armed_d = 1'b0;
          if (sel_valid(fr.sel)) begin
            sel_err_d = 1'b0;
            sel_d     = fr.sel;
            rd0_d     = ~fr.p0.csb & fr.p0.web;
            rd1_d     = ~fr.p1.csb & fr.p1.web;
            addr0_d   = fr.p0.addr;
            addr1_d   = fr.p1.addr;
            din0_d    = fr.p0.din;
            din1_d    = fr.p1.din;
            web0_d    = fr.p0.web;
            web1_d    = fr.p1.web;
            wmask0_d  = fr.p0.wmask;
            wmask1_d  = fr.p1.wmask;
            for (int k = 0; k < NUM_SRAM; k++) begin
              csb0_d[k] = (fr.sel == SEL_W'(k)) ? fr.p0.csb : 1'b1;
              csb1_d[k] = (fr.sel == SEL_W'(k)) ? fr.p1.csb : 1'b1;
            end
            state_d = ST_ACCESS;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        csb0_d  = '1;
        csb1_d  = '1;
        cnt_d   = '0;
        state_d = (rd0_q || rd1_q) ? ST_WAIT : ST_IDLE;
        if (load_req) load_pend_d = 1'b1;
      end
      ST_WAIT: begin
        if (load_req) load_pend_d = 1'b1;
        if (cnt_q == LAT_W'(READ_LAT - 1)) state_d = ST_CAPTURE;
        else                               cnt_d   = cnt_q + LAT_W'(1);
      end
      ST_CAPTURE: begin
        if (rd0_q) dout0_d = dsel0;
        if (rd1_q) dout1_d = dsel1;
        // Bypass so a load this cycle sees the data being captured
        ld0         = dout0_d;
        ld1         = dout1_d;
        load_en     = load_req || (load_pend_q && !scan_en);
        load_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rd0_q       <= 1'b0;
      rd1_q       <= 1'b0;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      load_pend_q <= 1'b0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      csb0_q      <= '1;
      csb1_q      <= '1;
      web0_q      <= 1'b1;
      web1_q      <= 1'b1;
      wmask0_q    <= '0;
      wmask1_q    <= '0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      din0_q      <= '0;
      din1_q      <= '0;
      busy_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      load_pend_q <= load_pend_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      csb0_q      <= csb0_d;
      csb1_q      <= csb1_d;
      web0_q      <= web0_d;
      web1_q      <= web1_d;
      wmask0_q    <= wmask0_d;
      wmask1_q    <= wmask1_d;
      addr0_q     <= addr0_d;
      addr1_q     <= addr1_d;
      din0_q      <= din0_d;
      din1_q      <= din1_d;
      busy_q      <= busy_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign sram_csb0   = csb0_q;
  assign sram_csb1   = csb1_q;
  assign sram_web0   = web0_q;
  assign sram_web1   = web1_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_wmask1 = wmask1_q;
  assign sram_addr0  = addr0_q;
  assign sram_addr1  = addr1_q;
  assign sram_din0   = din0_q;
  assign sram_din1   = din1_q;
  assign busy        = busy_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// tb_sram_scan_ctrl: self-checking bench for sram_scan_ctrl with a small
// behavioural dual-port SRAM array model.
`timescale 1ns/1ps
module tb_sram_scan_ctrl;
  import sram_scan_pkg::*;

  localparam int unsigned FW = 112;
  localparam int unsigned NS = 11;

  logic clk = 1'b0;
  logic resetn, scan_en, scan_in, scan_out, sram_load, global_csb;
  logic [NS-1:0] sram_csb0, sram_csb1;
  logic sram_web0, sram_web1;
  logic [3:0] sram_wmask0, sram_wmask1;
  logic [15:0] sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_din1;
  logic [NS*32-1:0] sram_dout0, sram_dout1;
  logic busy, sel_err;

  always #5 clk = ~clk;

  sram_scan_ctrl dut (
    .clk(clk), .resetn(resetn), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_out), .sram_load(sram_load), .global_csb(global_csb),
    .sram_csb0(sram_csb0), .sram_csb1(sram_csb1),
    .sram_web0(sram_web0), .sram_web1(sram_web1),
    .sram_wmask0(sram_wmask0), .sram_wmask1(sram_wmask1),
    .sram_addr0(sram_addr0), .sram_addr1(sram_addr1),
    .sram_din0(sram_din0), .sram_din1(sram_din1),
    .sram_dout0(sram_dout0), .sram_dout1(sram_dout1),
    .busy(busy), .sel_err(sel_err)
  );

  // Behavioural macros: sample on the edge csb is seen low, dout next cycle
  logic [31:0] mem [NS][16];
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (sram_csb0[k] == 1'b0) begin
        if (!sram_web0) begin
          for (int b = 0; b < 4; b++)
            if (sram_wmask0[b]) mem[k][sram_addr0[3:0]][8*b +: 8] <= sram_din0[8*b +: 8];
        end else sram_dout0[k*32 +: 32] <= mem[k][sram_addr0[3:0]];
      end
      if (sram_csb1[k] == 1'b0) begin
        if (!sram_web1) begin
          for (int b = 0; b < 4; b++)
            if (sram_wmask1[b]) mem[k][sram_addr1[3:0]][8*b +: 8] <= sram_din1[8*b +: 8];
        end else sram_dout1[k*32 +: 32] <= mem[k][sram_addr1[3:0]];
      end
    end
  end

  // csb-low monitor: cycles on the expected slot vs any other slot
  int lo0_cnt, lo1_cnt, lo_bad;
  logic [3:0] mon_sel;
  always @(negedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (sram_csb0[k] !== 1'b1) begin
        if (4'(k) == mon_sel) lo0_cnt++; else lo_bad++;
      end
      if (sram_csb1[k] !== 1'b1) begin
        if (4'(k) == mon_sel) lo1_cnt++; else lo_bad++;
      end
    end
  end

  int tests = 0;
  int fails = 0;
  logic [FW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] sel;
    logic [15:0] a0; logic [31:0] d0; logic c0; logic w0; logic [3:0] m0;
    logic [15:0] a1; logic [31:0] d1; logic c1; logic w1; logic [3:0] m1;
    logic err; logic chk; logic [31:0] e0; logic [31:0] e1;
  } vec_t;

  function automatic vec_t mv(input logic [3:0] sel,
      input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
      input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1, input logic [3:0] m1,
      input logic err, input logic ck, input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.sel = sel; v.a0 = a0; v.d0 = d0; v.c0 = c0; v.w0 = w0; v.m0 = m0;
    v.a1 = a1; v.d1 = d1; v.c1 = c1; v.w1 = w1; v.m1 = m1;
    v.err = err; v.chk = ck; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // Frame layout {sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1}
  function automatic logic [FW-1:0] mk(input vec_t v, input logic [31:0] din0, input logic [31:0] din1);
    return {v.sel, v.a0, din0, v.c0, v.w0, v.m0, v.a1, din1, v.c1, v.w1, v.m1};
  endfunction

  // Shift f in MSB-first while capturing the previous frame from scan_out
  task automatic shift_frame(input logic [FW-1:0] f, output logic [FW-1:0] got);
    for (int i = FW - 1; i >= 0; i--) begin
      @(negedge clk);
      got[i]  = scan_out;
      scan_en = 1'b1;
      scan_in = f[i];
    end
    @(negedge clk);
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: busy=%b after %0d cycles, required 0", nm, busy, n);
    end
  endtask

  // Pop scoreboard entry and compare against the shifted-out frame
  task automatic check_out(input string nm);
    logic [FW-1:0] got, exp;
    shift_frame('0, got);
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: got %h, required nothing (scoreboard empty)", nm, got);
    end else begin
      exp = exp_q.pop_front();
      chk(nm, got, exp);
    end
  endtask

  task automatic arm_mon(input logic [3:0] s);
    mon_sel = s; lo0_cnt = 0; lo1_cnt = 0; lo_bad = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [FW-1:0] got;
    string nm;
    nm = $sformatf("v%0d", idx);
    shift_frame(mk(v, v.d0, v.d1), got);
    arm_mon(v.sel);
    global_csb = 1'b0;
    @(negedge clk);
    global_csb = 1'b1;
    wait_idle(nm);
    @(negedge clk);
    chk({nm, " sel_err"}, FW'(sel_err), FW'(v.err));
    chk({nm, " csb0_low"}, FW'(lo0_cnt), FW'((!v.err && !v.c0) ? 1 : 0));
    chk({nm, " csb1_low"}, FW'(lo1_cnt), FW'((!v.err && !v.c1) ? 1 : 0));
    chk({nm, " csb_other"}, FW'(lo_bad), FW'(0));
    if (v.chk) begin
      sram_load = 1'b1;
      exp_q.push_back(mk(v, v.e0, v.e1));
      @(negedge clk);
      sram_load = 1'b0;
      check_out({nm, " frame"});
    end
  endtask

  vec_t vt[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] got;
    vec_t h;

    for (int k = 0; k < NS; k++) for (int a = 0; a < 16; a++) mem[k][a] = '0;
    sram_dout0 = '0; sram_dout1 = '0;
    resetn = 1'b0; scan_en = 1'b0; scan_in = 1'b0; sram_load = 1'b0; global_csb = 1'b1;
    arm_mon(4'd0);

    //            sel  a0     d0            c0   w0   m0     a1     d1            c1   w1   m1    err  chk  e0            e1
    vt[0]  = mv(4'd8,  16'h1, 32'hDEADBEEF, 1'b0,1'b0,4'hF, 16'h0, 32'h0,        1'b1,1'b1,4'h0, 1'b0,1'b0,32'h0,        32'h0);
    vt[1]  = mv(4'd8,  16'h1, 32'h0,        1'b0,1'b1,4'h0, 16'h7, 32'h11111111, 1'b1,1'b1,4'h0, 1'b0,1'b1,32'hDEADBEEF, 32'h0);
    vt[2]  = mv(4'd3,  16'h1, 32'h3,        1'b0,1'b0,4'hF, 16'h0, 32'h0,        1'b1,1'b1,4'h0, 1'b0,1'b0,32'h0,        32'h0);
    vt[3]  = mv(4'd3,  16'h0, 32'h0,        1'b1,1'b1,4'h0, 16'h2, 32'h18,       1'b0,1'b0,4'hF, 1'b0,1'b0,32'h0,        32'h0);
    vt[4]  = mv(4'd3,  16'h1, 32'h0,        1'b0,1'b1,4'h0, 16'h2, 32'h0,        1'b0,1'b1,4'h0, 1'b0,1'b1,32'h3,        32'h18);
    vt[5]  = mv(4'd0,  16'h5, 32'h12345678, 1'b0,1'b0,4'h3, 16'h0, 32'h0,        1'b1,1'b1,4'h0, 1'b0,1'b0,32'h0,        32'h0);
    vt[6]  = mv(4'd0,  16'h5, 32'h0,        1'b0,1'b1,4'h0, 16'h5, 32'h0,        1'b0,1'b1,4'h0, 1'b0,1'b1,32'h5678,     32'h5678);
    vt[7]  = mv(4'd10, 16'h0, 32'h0,        1'b1,1'b1,4'h0, 16'h3, 32'hA5A50F0F, 1'b0,1'b0,4'hF, 1'b0,1'b0,32'h0,        32'h0);
    vt[8]  = mv(4'd10, 16'h0, 32'h0,        1'b1,1'b1,4'h0, 16'h3, 32'h0,        1'b0,1'b1,4'h0, 1'b0,1'b1,32'h5678,     32'hA5A50F0F);
    vt[9]  = mv(4'd7,  16'h1, 32'hCAFEF00D, 1'b0,1'b0,4'hF, 16'h0, 32'h0,        1'b1,1'b1,4'h0, 1'b1,1'b0,32'h0,        32'h0);
    vt[10] = mv(4'd12, 16'h1, 32'h0,        1'b0,1'b1,4'h0, 16'h1, 32'h0,        1'b0,1'b1,4'h0, 1'b1,1'b1,32'h5678,     32'hA5A50F0F);
    vt[11] = mv(4'd3,  16'h2, 32'h0,        1'b0,1'b1,4'h0, 16'h1, 32'h0,        1'b0,1'b1,4'h0, 1'b0,1'b1,32'h18,       32'h3);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst scan_out", FW'(scan_out), FW'(0));
    chk("rst csb0", FW'(sram_csb0), FW'(11'h7FF));
    chk("rst csb1", FW'(sram_csb1), FW'(11'h7FF));
    chk("rst web", FW'({sram_web0, sram_web1}), FW'(2'b11));
    chk("rst addr", FW'({sram_addr0, sram_addr1}), FW'(0));
    chk("rst din", FW'({sram_din0, sram_din1, sram_wmask0, sram_wmask1}), FW'(0));
    chk("rst busy", FW'(busy), FW'(0));
    chk("rst sel_err", FW'(sel_err), FW'(0));
    resetn = 1'b1;
    shift_frame('0, got);
    chk("rst frame", got, '0);

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Load requested while WAIT: applied when data is captured
    h = mv(4'd3, 16'h1, 32'h0, 1'b0, 1'b1, 4'h0, 16'h2, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 32'h3, 32'h18);
    shift_frame(mk(h, 32'hFFFFFFFF, 32'hFFFFFFFF), got);
    arm_mon(4'd3);
    global_csb = 1'b0;
    @(negedge clk);
    global_csb = 1'b1;
    @(negedge clk);
    chk("wait busy", FW'(busy), FW'(1));
    sram_load = 1'b1;
    @(negedge clk);
    sram_load = 1'b0;
    wait_idle("wait_load");
    exp_q.push_back(mk(h, 32'h3, 32'h18));
    check_out("wait_load frame");

    // global_csb held low past the access: only one access
    h = mv(4'd3, 16'h1, 32'h0, 1'b0, 1'b1, 4'h0, 16'h0, 32'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 32'h3, 32'h18);
    shift_frame(mk(h, 32'h0, 32'h0), got);
    arm_mon(4'd3);
    global_csb = 1'b0;
    repeat (5) @(negedge clk);
    global_csb = 1'b1;
    wait_idle("hold_low");
    @(negedge clk);
    chk("hold_low csb0_low", FW'(lo0_cnt), FW'(1));
    chk("hold_low csb1_low", FW'(lo1_cnt), FW'(0));
    chk("hold_low csb_other", FW'(lo_bad), FW'(0));
    sram_load = 1'b1;
    exp_q.push_back(mk(h, 32'h3, 32'h18));
    @(negedge clk);
    sram_load = 1'b0;
    check_out("hold_low frame");

    // Reset asserted in ACCESS drops csb asynchronously
    h = mv(4'd5, 16'h4, 32'h77, 1'b0, 1'b0, 4'hF, 16'h0, 32'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    shift_frame(mk(h, h.d0, h.d1), got);
    arm_mon(4'd5);
    global_csb = 1'b0;
    @(negedge clk);
    global_csb = 1'b1;
    chk("access csb0", FW'(sram_csb0), FW'(11'h7DF));
    #1 resetn = 1'b0;
    #1;
    chk("async csb0", FW'(sram_csb0), FW'(11'h7FF));
    chk("async busy", FW'(busy), FW'(0));
    chk("async scan_out", FW'(scan_out), FW'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst busy", FW'(busy), FW'(0));
    shift_frame('0, got);
    chk("post_rst frame", got, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
